cache_wb_unit: RTL and testbench

- Victim writeback engine for the data cache.
- Accepts one evicted 128-bit line, four words wide, as read from the four-bank data array, together with its line address.
- Serializes the line into four 32-bit write beats on the memory-side write channel, then waits for the write response.
- Holds the line as a one-entry victim buffer while busy, so the cache can forward hits on an in-flight eviction.

---
 rtl/cache_wb_unit_pkg.sv | 31 +++
 rtl/cache_wb_unit_if.sv | 58 +++++
 rtl/cache_wb_unit_line_word_mux.sv | 23 ++
 rtl/cache_wb_unit.sv | 175 +++++++++++++++++
 tb/tb_cache_wb_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_wb_unit_pkg.sv
// cache_wb_unit_pkg: shared widths, state encoding and response codes for the
// victim writeback engine.
// Contents: line geometry constants, wb_state_e, BRESP_OKAY, wb_beat_t payload.
package cache_wb_unit_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned CACHE_BANK_NUM = 4;
  localparam int unsigned CACHE_LINE_W   = DATA_WIDTH * CACHE_BANK_NUM;
  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned BEAT_W         = 2;
  localparam int unsigned LINE_OFF_W     = 4;
  localparam int unsigned WSTRB_W        = 4;
  localparam int unsigned BRESP_W        = 2;

  localparam logic [BRESP_W-1:0] BRESP_OKAY = 2'b00;
  localparam logic [WSTRB_W-1:0] WSTRB_FULL = 4'hF;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_SEND = 2'd1,
    WB_WAIT = 2'd2
  } wb_state_e;

  // One write beat as seen on the memory-side channel.
  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      last;
  } wb_beat_t;

endpackage

// File: rtl/cache_wb_unit_if.sv
// cache_wb_unit_if: bundles the cache-side writeback request, the memory-side
// write channel and the victim-buffer probe of cache_wb_unit.
// Modports: slave = the writeback engine, master = cache/memory environment.
interface cache_wb_unit_if
  import cache_wb_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned WORD_W     = DATA_WIDTH,
  parameter int unsigned BEATS      = CACHE_BANK_NUM
);

  // Cache-side request
  logic                      wb_req_i;
  logic [ADDR_WIDTH-1:0]     wb_addr_i;
  logic [BEATS*WORD_W-1:0]   wb_data_i;
  logic                      wb_ready_o;
  logic                      wb_done_o;
  logic                      wb_err_o;

  // Memory-side write channel
  logic                      bus_awvalid_o;
  logic                      bus_awready_i;
  logic [ADDR_WIDTH-1:0]     bus_addr_o;
  logic [WORD_W-1:0]         bus_wdata_o;
  logic [WSTRB_W-1:0]        bus_wstrb_o;
  logic                      bus_wlast_o;
  logic                      bus_bvalid_i;
  logic [BRESP_W-1:0]        bus_bresp_i;
  logic                      bus_bready_o;

  // Victim-buffer probe
  logic [ADDR_WIDTH-1:0]     probe_addr_i;
  logic                      probe_hit_o;
  logic [WORD_W-1:0]         probe_data_o;

  modport slave (
    input  wb_req_i, wb_addr_i, wb_data_i,
    output wb_ready_o, wb_done_o, wb_err_o,
    output bus_awvalid_o, bus_addr_o, bus_wdata_o, bus_wstrb_o, bus_wlast_o,
    input  bus_awready_i,
    input  bus_bvalid_i, bus_bresp_i,
    output bus_bready_o,
    input  probe_addr_i,
    output probe_hit_o, probe_data_o
  );

  modport master (
    output wb_req_i, wb_addr_i, wb_data_i,
    input  wb_ready_o, wb_done_o, wb_err_o,
    input  bus_awvalid_o, bus_addr_o, bus_wdata_o, bus_wstrb_o, bus_wlast_o,
    output bus_awready_i,
    output bus_bvalid_i, bus_bresp_i,
    input  bus_bready_o,
    output probe_addr_i,
    input  probe_hit_o, probe_data_o
  );

endinterface

// File: rtl/cache_wb_unit_line_word_mux.sv
// line_word_mux: selects one WORD_W word out of a packed cache line.
// Ports: line_i (WORDS*WORD_W line, word k at [k*WORD_W +: WORD_W]),
//        idx_i (word index), word_o (selected word, combinational).
module line_word_mux #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [WORDS*WORD_W-1:0] line_i,
  input  logic [IDX_W-1:0]        idx_i,
  output logic [WORD_W-1:0]       word_o
);

  always_comb begin
    word_o = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_i == IDX_W'(k)) begin
        word_o = line_i[k*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/cache_wb_unit.sv
// cache_wb_unit: victim writeback engine. Takes one evicted line plus its
// address, emits it as four word beats on the write channel, waits for the
// write response, and exposes the in-flight line to cache probes.
// Ports: clk, rst (sync, active high), io (cache_wb_unit_if.slave):
//   wb_req/addr/data in, wb_ready/done/err out; bus_aw*/w* beats out with
//   awready in; bvalid/bresp in, bready out; probe_addr in, probe_hit/data out.
module cache_wb_unit
  import cache_wb_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned WORD_W     = DATA_WIDTH,
  parameter int unsigned BEATS      = CACHE_BANK_NUM
) (
  input  logic            clk,
  input  logic            rst,
  cache_wb_unit_if.slave  io
);

  localparam int unsigned      LINE_W    = WORD_W * BEATS;
  localparam int unsigned      BASE_W    = ADDR_WIDTH - LINE_OFF_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  wb_state_e               state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [BASE_W-1:0]       base_q, base_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic                    wb_ready_q, wb_ready_d;
  logic                    wb_done_q, wb_done_d;
  logic                    wb_err_q, wb_err_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wlast_q, wlast_d;
  logic                    bready_q, bready_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]       wdata_q, wdata_d;

  logic [WORD_W-1:0]       beat_word;
  logic [WORD_W-1:0]       probe_word;
  logic                    probe_hit;

  // Byte offsets of the incoming address and the probe are don't-care.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{io.wb_addr_i[LINE_OFF_W-1:0], io.probe_addr_i[1:0]};

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    base_d     = base_q;
    line_d     = line_q;
    wb_ready_d = wb_ready_q;
    wb_done_d  = 1'b0;
    wb_err_d   = 1'b0;
    awvalid_d  = awvalid_q;
    wlast_d    = wlast_q;
    bready_d   = bready_q;

    unique case (state_q)
      WB_IDLE: begin
        wb_ready_d = 1'b1;
        if (io.wb_req_i) begin
          base_d     = io.wb_addr_i[ADDR_WIDTH-1:LINE_OFF_W];
          line_d     = io.wb_data_i;
          beat_d     = '0;
          awvalid_d  = 1'b1;
          wlast_d    = (LAST_BEAT == '0);
          wb_ready_d = 1'b0;
          state_d    = WB_SEND;
        end
      end

      WB_SEND: begin
        wb_ready_d = 1'b0;
        if (awvalid_q && io.bus_awready_i) begin
          if (beat_q == LAST_BEAT) begin
            awvalid_d = 1'b0;
            wlast_d   = 1'b0;
            bready_d  = 1'b1;
            state_d   = WB_WAIT;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            wlast_d = (beat_d == LAST_BEAT);
          end
        end
      end

      WB_WAIT: begin
        bready_d = 1'b1;
        if (io.bus_bvalid_i) begin
          wb_done_d  = 1'b1;
          wb_err_d   = (io.bus_bresp_i != BRESP_OKAY);
          bready_d   = 1'b0;
          wb_ready_d = 1'b1;
          state_d    = WB_IDLE;
        end
      end

      default: begin
        state_d = WB_IDLE;
      end
    endcase
  end

  // Beat address and data follow the next beat index so they are registered
  // together with awvalid; the address never carries past the line.
  assign addr_d  = {base_d, beat_d, 2'b00};
  assign wdata_d = beat_word;

  line_word_mux #(
    .WORD_W (WORD_W),
    .WORDS  (BEATS),
    .IDX_W  (BEAT_W)
  ) u_beat_mux (
    .line_i (line_d),
    .idx_i  (beat_d),
    .word_o (beat_word)
  );

  line_word_mux #(
    .WORD_W (WORD_W),
    .WORDS  (BEATS),
    .IDX_W  (BEAT_W)
  ) u_probe_mux (
    .line_i (line_q),
    .idx_i  (io.probe_addr_i[LINE_OFF_W-1:2]),
    .word_o (probe_word)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WB_IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      line_q     <= '0;
      wb_ready_q <= 1'b1;
      wb_done_q  <= 1'b0;
      wb_err_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wlast_q    <= 1'b0;
      bready_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      line_q     <= line_d;
      wb_ready_q <= wb_ready_d;
      wb_done_q  <= wb_done_d;
      wb_err_q   <= wb_err_d;
      awvalid_q  <= awvalid_d;
      wlast_q    <= wlast_d;
      bready_q   <= bready_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Probe only matches while a line is actually in flight.
  assign probe_hit = (state_q != WB_IDLE) &&
                     (io.probe_addr_i[ADDR_WIDTH-1:LINE_OFF_W] == base_q);

  assign io.wb_ready_o    = wb_ready_q;
  assign io.wb_done_o     = wb_done_q;
  assign io.wb_err_o      = wb_err_q;
  assign io.bus_awvalid_o = awvalid_q;
  assign io.bus_addr_o    = addr_q;
  assign io.bus_wdata_o   = wdata_q;
  assign io.bus_wstrb_o   = WSTRB_FULL;
  assign io.bus_wlast_o   = wlast_q;
  assign io.bus_bready_o  = bready_q;
  assign io.probe_hit_o   = probe_hit;
  assign io.probe_data_o  = probe_hit ? probe_word : '0;

endmodule

// File: tb/tb_cache_wb_unit.sv
// tb_cache_wb_unit: self-checking bench for cache_wb_unit. Expected beats are
// queued when a request is driven and compared as the DUT presents them.
module tb_cache_wb_unit;
  import cache_wb_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_wb_unit_if #(.ADDR_WIDTH(32), .WORD_W(32), .BEATS(4)) cwb ();

  cache_wb_unit dut (
    .clk (clk),
    .rst (rst),
    .io  (cwb)
  );

  int n_checks = 0;
  int n_fail   = 0;
  wb_beat_t exp_q[$];

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [7:0]   pat;
    logic [1:0]   bresp;
    int           bdelay;
    logic         exp_err;
    logic         probe;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [31:0] addr, input logic [127:0] data);
    wb_beat_t e;
    for (int k = 0; k < 4; k++) begin
      e.addr  = {addr[31:4], 4'b0000} + 32'(k * 4);
      e.wdata = data[k*32 +: 32];
      e.last  = (k == 3);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_req(input logic [31:0] addr, input logic [127:0] data);
    int w = 0;
    while (!cwb.wb_ready_o && w < 20) begin
      tick();
      w++;
    end
    chk("req_ready", 128'(cwb.wb_ready_o), 128'(1));
    cwb.wb_req_i  = 1'b1;
    cwb.wb_addr_i = addr;
    cwb.wb_data_i = data;
    push_line(addr, data);
    tick();
    cwb.wb_req_i = 1'b0;
    chk("first_valid", 128'(cwb.bus_awvalid_o), 128'(1));
    chk("busy_ready", 128'(cwb.wb_ready_o), 128'(0));
  endtask

  // Drives awready from an 8-cycle pattern (bit 0 first) until 4 handshakes.
  task automatic run_burst(input logic [7:0] pat);
    int hs = 0;
    int cyc = 0;
    wb_beat_t e;
    while (hs < 4 && cyc < 40) begin
      cwb.bus_awready_i = pat[3'(cyc)];
      if (cwb.bus_awvalid_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: actual=beat addr %0h required=no beat", cwb.bus_addr_o);
        end else begin
          e = exp_q[0];
          chk("beat_addr", 128'(cwb.bus_addr_o), 128'(e.addr));
          chk("beat_data", 128'(cwb.bus_wdata_o), 128'(e.wdata));
          chk("beat_last", 128'(cwb.bus_wlast_o), 128'(e.last));
          chk("beat_strb", 128'(cwb.bus_wstrb_o), 128'(4'hF));
          if (cwb.bus_awready_i) begin
            void'(exp_q.pop_front());
            hs++;
          end
        end
      end
      tick();
      cyc++;
    end
    cwb.bus_awready_i = 1'b0;
    chk("burst_handshakes", 128'(hs), 128'(4));
    if (pat == 8'hFF) chk("burst_cycles", 128'(cyc), 128'(4));
    chk("wait_awvalid", 128'(cwb.bus_awvalid_o), 128'(0));
    chk("wait_bready", 128'(cwb.bus_bready_o), 128'(1));
    chk("wait_ready", 128'(cwb.wb_ready_o), 128'(0));
  endtask

  // Returns in the cycle where done is expected high.
  task automatic resp(input logic [1:0] bresp, input int delay, input logic exp_err,
                      input logic do_probe);
    for (int i = 0; i < delay; i++) begin
      chk("no_early_done", 128'(cwb.wb_done_o), 128'(0));
      chk("bready_held", 128'(cwb.bus_bready_o), 128'(1));
      if (do_probe && i == 0) begin
        cwb.probe_addr_i = 32'h8000_0128;
        #1;
        chk("probe_hit_in", 128'(cwb.probe_hit_o), 128'(1));
        chk("probe_data_in", 128'(cwb.probe_data_o), 128'(32'hCCCC_CCCC));
      end
      if (do_probe && i == 1) begin
        cwb.probe_addr_i = 32'h8000_0130;
        #1;
        chk("probe_hit_other", 128'(cwb.probe_hit_o), 128'(0));
        chk("probe_data_other", 128'(cwb.probe_data_o), 128'(0));
      end
      tick();
    end
    cwb.bus_bvalid_i = 1'b1;
    cwb.bus_bresp_i  = bresp;
    tick();
    cwb.bus_bvalid_i = 1'b0;
    cwb.bus_bresp_i  = 2'b00;
    chk("done_pulse", 128'(cwb.wb_done_o), 128'(1));
    chk("done_err", 128'(cwb.wb_err_o), 128'(exp_err));
    chk("done_ready", 128'(cwb.wb_ready_o), 128'(1));
    chk("done_bready", 128'(cwb.bus_bready_o), 128'(0));
    if (do_probe) begin
      cwb.probe_addr_i = 32'h8000_0128;
      #1;
      chk("probe_hit_after", 128'(cwb.probe_hit_o), 128'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cwb.wb_req_i      = 1'b0;
    cwb.wb_addr_i     = '0;
    cwb.wb_data_i     = '0;
    cwb.bus_awready_i = 1'b0;
    cwb.bus_bvalid_i  = 1'b0;
    cwb.bus_bresp_i   = 2'b00;
    cwb.probe_addr_i  = '0;
    rst = 1'b1;

    vecs[0] = '{32'h8000_0124, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 8'hFF, 2'b00, 2, 1'b0, 1'b1};
    vecs[1] = '{32'h1234_567C, 128'h01234567_89ABCDEF_DEADBEEF_CAFEF00D, 8'b1011_0100, 2'b00, 0, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0FF0, 128'h11111111_22222222_33333333_44444444, 8'hFF, 2'b10, 1, 1'b1, 1'b0};
    vecs[3] = '{32'hFFFF_FFFC, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 8'b1011_0100, 2'b11, 3, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0008, 128'h00000004_00000003_00000002_00000001, 8'b0101_0101, 2'b01, 0, 1'b1, 1'b0};

    repeat (3) tick();
    chk("rst_ready", 128'(cwb.wb_ready_o), 128'(1));
    chk("rst_done", 128'(cwb.wb_done_o), 128'(0));
    chk("rst_err", 128'(cwb.wb_err_o), 128'(0));
    chk("rst_awvalid", 128'(cwb.bus_awvalid_o), 128'(0));
    chk("rst_wlast", 128'(cwb.bus_wlast_o), 128'(0));
    chk("rst_bready", 128'(cwb.bus_bready_o), 128'(0));
    chk("rst_addr", 128'(cwb.bus_addr_o), 128'(0));
    chk("rst_wdata", 128'(cwb.bus_wdata_o), 128'(0));
    chk("rst_wstrb", 128'(cwb.bus_wstrb_o), 128'(4'hF));
    chk("rst_probe_hit", 128'(cwb.probe_hit_o), 128'(0));
    chk("rst_probe_data", 128'(cwb.probe_data_o), 128'(0));
    rst = 1'b0;
    tick();

    // Stray response while idle must not retire anything.
    cwb.bus_bvalid_i = 1'b1;
    cwb.bus_bresp_i  = 2'b10;
    tick();
    cwb.bus_bvalid_i = 1'b0;
    cwb.bus_bresp_i  = 2'b00;
    chk("idle_bvalid_done", 128'(cwb.wb_done_o), 128'(0));
    chk("idle_bvalid_ready", 128'(cwb.wb_ready_o), 128'(1));

    for (int v = 0; v < 5; v++) begin
      start_req(vecs[v].addr, vecs[v].data);
      run_burst(vecs[v].pat);
      resp(vecs[v].bresp, vecs[v].bdelay, vecs[v].exp_err, vecs[v].probe);
      tick();
      chk("done_one_cycle", 128'(cwb.wb_done_o), 128'(0));
      chk("idle_ready", 128'(cwb.wb_ready_o), 128'(1));
    end

    // Second request held during a busy line is ignored, then taken after done.
    start_req(32'h4000_0010, 128'h13131313_12121212_11111111_10101010);
    cwb.wb_req_i  = 1'b1;
    cwb.wb_addr_i = 32'h4000_0A04;
    cwb.wb_data_i = 128'h23232323_22222222_21212121_20202020;
    run_burst(8'hFF);
    resp(2'b00, 1, 1'b0, 1'b0);
    push_line(32'h4000_0A04, 128'h23232323_22222222_21212121_20202020);
    tick();
    cwb.wb_req_i = 1'b0;
    chk("busy_retry_valid", 128'(cwb.bus_awvalid_o), 128'(1));
    chk("busy_retry_done", 128'(cwb.wb_done_o), 128'(0));
    run_burst(8'hFF);
    resp(2'b00, 0, 1'b0, 1'b0);
    tick();
    chk("busy_final_done", 128'(cwb.wb_done_o), 128'(0));

    // Reset after the second beat handshake aborts the line.
    start_req(32'h0000_7770, 128'h77777773_77777772_77777771_77777770);
    cwb.bus_awready_i = 1'b1;
    chk("abort_b0_addr", 128'(cwb.bus_addr_o), 128'(32'h0000_7770));
    tick();
    chk("abort_b1_addr", 128'(cwb.bus_addr_o), 128'(32'h0000_7774));
    chk("abort_b1_data", 128'(cwb.bus_wdata_o), 128'(32'h7777_7771));
    tick();
    cwb.bus_awready_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("abort_awvalid", 128'(cwb.bus_awvalid_o), 128'(0));
    chk("abort_ready", 128'(cwb.wb_ready_o), 128'(1));
    chk("abort_done", 128'(cwb.wb_done_o), 128'(0));
    chk("abort_bready", 128'(cwb.bus_bready_o), 128'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 128'(cwb.wb_done_o), 128'(0));
    end
    start_req(32'h0000_9998, 128'h99999993_99999992_99999991_99999990);
    run_burst(8'hFF);
    resp(2'b00, 1, 1'b0, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
